// File: rtl/spr_16x8_arbiter.sv
// Two-port arbiter/sequencer sharing one spr_16x8 single-port RAM.
// One command per grant: IDLE -> ACCESS -> CAPTURE -> IDLE, all RAM pins driven from flops.
module spr_16x8_arbiter #(
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned FIX_PRI = 0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ0,
  input  logic              WEN0,
  input  logic [ADDR_W-1:0] ADDR0,
  input  logic [DATA_W-1:0] DATA0,
  output logic              GNT0,
  output logic              DONE0,
  output logic [DATA_W-1:0] RDATA0,
  input  logic              REQ1,
  input  logic              WEN1,
  input  logic [ADDR_W-1:0] ADDR1,
  input  logic [DATA_W-1:0] DATA1,
  output logic              GNT1,
  output logic              DONE1,
  output logic [DATA_W-1:0] RDATA1,
  output logic              MEM_WEN,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_DATA,
  input  logic [DATA_W-1:0] MEM_Q,
  output logic              BUSY
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t state;
  logic   rr_ptr;
  logic   win;
  logic   op_rd;
  logic   pick_c;

  // Winner selection: lone requester wins; a tie goes to the pointer or to port 0.
  always_comb begin
    pick_c = REQ1;
    if (REQ0 && REQ1) begin
      pick_c = (FIX_PRI != 0) ? 1'b0 : rr_ptr;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      rr_ptr   <= 1'b0;
      win      <= 1'b0;
      op_rd    <= 1'b0;
      GNT0     <= 1'b0;
      GNT1     <= 1'b0;
      DONE0    <= 1'b0;
      DONE1    <= 1'b0;
      RDATA0   <= '0;
      RDATA1   <= '0;
      MEM_WEN  <= 1'b0;
      MEM_ADDR <= '0;
      MEM_DATA <= '0;
      BUSY     <= 1'b0;
    end else begin
      GNT0  <= 1'b0;
      GNT1  <= 1'b0;
      DONE0 <= 1'b0;
      DONE1 <= 1'b0;
      case (state)
        IDLE: begin
          if (REQ0 || REQ1) begin
            win      <= pick_c;
            op_rd    <= pick_c ? ~WEN1 : ~WEN0;
            MEM_WEN  <= pick_c ? WEN1 : WEN0;
            MEM_ADDR <= pick_c ? ADDR1 : ADDR0;
            MEM_DATA <= pick_c ? DATA1 : DATA0;
            GNT0     <= ~pick_c;
            GNT1     <= pick_c;
            rr_ptr   <= ~rr_ptr;
            BUSY     <= 1'b1;
            state    <= ACCESS;
          end
        end
        ACCESS: begin
          // RAM samples the pins on this edge; write strobe is exactly one cycle.
          MEM_WEN <= 1'b0;
          state   <= CAPTURE;
        end
        CAPTURE: begin
          if (op_rd) begin
            if (win) RDATA1 <= MEM_Q;
            else     RDATA0 <= MEM_Q;
          end
          DONE0 <= ~win;
          DONE1 <= win;
          BUSY  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          MEM_WEN <= 1'b0;
          BUSY    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spr_16x8_arbiter.sv
// Directed bench for spr_16x8_arbiter: round-robin and fixed-priority instances, each with a RAM model.
module tb_spr_16x8_arbiter;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       REQ0 = 1'b0, WEN0 = 1'b0, REQ1 = 1'b0, WEN1 = 1'b0;
  logic [3:0] ADDR0 = '0, ADDR1 = '0;
  logic [7:0] DATA0 = '0, DATA1 = '0;

  logic       rr_gnt0, rr_gnt1, rr_done0, rr_done1, rr_mem_wen, rr_busy;
  logic [7:0] rr_rdata0, rr_rdata1, rr_mem_data, rr_mem_q;
  logic [3:0] rr_mem_addr;
  logic       fp_gnt0, fp_gnt1, fp_done0, fp_done1, fp_mem_wen, fp_busy;
  logic [7:0] fp_rdata0, fp_rdata1, fp_mem_data, fp_mem_q;
  logic [3:0] fp_mem_addr;

  logic [7:0] mem_rr [16];
  logic [7:0] mem_fp [16];

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [7:0] exp_rd0 = '0, exp_rd1 = '0;
  logic [3:0] last_addr = '0;
  logic [7:0] last_data = '0;

  always #5 CLK = ~CLK;

  spr_16x8_arbiter #(.ADDR_W(4), .DATA_W(8), .FIX_PRI(0)) u_rr (
    .CLK(CLK), .RST(RST),
    .REQ0(REQ0), .WEN0(WEN0), .ADDR0(ADDR0), .DATA0(DATA0),
    .GNT0(rr_gnt0), .DONE0(rr_done0), .RDATA0(rr_rdata0),
    .REQ1(REQ1), .WEN1(WEN1), .ADDR1(ADDR1), .DATA1(DATA1),
    .GNT1(rr_gnt1), .DONE1(rr_done1), .RDATA1(rr_rdata1),
    .MEM_WEN(rr_mem_wen), .MEM_ADDR(rr_mem_addr), .MEM_DATA(rr_mem_data),
    .MEM_Q(rr_mem_q), .BUSY(rr_busy)
  );

  spr_16x8_arbiter #(.ADDR_W(4), .DATA_W(8), .FIX_PRI(1)) u_fp (
    .CLK(CLK), .RST(RST),
    .REQ0(REQ0), .WEN0(WEN0), .ADDR0(ADDR0), .DATA0(DATA0),
    .GNT0(fp_gnt0), .DONE0(fp_done0), .RDATA0(fp_rdata0),
    .REQ1(REQ1), .WEN1(WEN1), .ADDR1(ADDR1), .DATA1(DATA1),
    .GNT1(fp_gnt1), .DONE1(fp_done1), .RDATA1(fp_rdata1),
    .MEM_WEN(fp_mem_wen), .MEM_ADDR(fp_mem_addr), .MEM_DATA(fp_mem_data),
    .MEM_Q(fp_mem_q), .BUSY(fp_busy)
  );

  // Synchronous single-port RAM models: Q registered from Addr, write on WEN.
  initial begin
    for (int i = 0; i < 16; i++) begin
      mem_rr[i] = 8'h00;
      mem_fp[i] = 8'h00;
    end
  end

  always @(posedge CLK) begin
    rr_mem_q <= mem_rr[rr_mem_addr];
    if (rr_mem_wen) mem_rr[rr_mem_addr] <= rr_mem_data;
    fp_mem_q <= mem_fp[fp_mem_addr];
    if (fp_mem_wen) mem_fp[fp_mem_addr] <= fp_mem_data;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // One full transaction on the round-robin instance; entered 1 time unit after an edge, DUT idle.
  task automatic do_txn(input logic port, input logic wen, input logic [3:0] addr,
                        input logic [7:0] data, input logic [7:0] exp_rd);
    if (!port) begin REQ0 = 1'b1; WEN0 = wen; ADDR0 = addr; DATA0 = data; end
    else       begin REQ1 = 1'b1; WEN1 = wen; ADDR1 = addr; DATA1 = data; end
    step();
    check("gnt_winner", 32'(port ? rr_gnt1 : rr_gnt0), 32'd1);
    check("gnt_other", 32'(port ? rr_gnt0 : rr_gnt1), 32'd0);
    check("mem_wen_access", 32'(rr_mem_wen), 32'(wen));
    check("mem_addr", 32'(rr_mem_addr), 32'(addr));
    check("mem_data", 32'(rr_mem_data), 32'(data));
    REQ0 = 1'b0;
    REQ1 = 1'b0;
    step();
    check("mem_wen_capture", 32'(rr_mem_wen), 32'd0);
    check("gnt_one_cycle", 32'(rr_gnt0 | rr_gnt1), 32'd0);
    check("busy_mid", 32'(rr_busy), 32'd1);
    check("done_early", 32'(rr_done0 | rr_done1), 32'd0);
    step();
    if (!wen) begin
      if (port) exp_rd1 = exp_rd;
      else      exp_rd0 = exp_rd;
    end
    check("done_winner", 32'(port ? rr_done1 : rr_done0), 32'd1);
    check("done_other", 32'(port ? rr_done0 : rr_done1), 32'd0);
    check("rdata0", 32'(rr_rdata0), 32'(exp_rd0));
    check("rdata1", 32'(rr_rdata1), 32'(exp_rd1));
    step();
    check("done_one_cycle", 32'(rr_done0 | rr_done1), 32'd0);
    check("busy_end", 32'(rr_busy), 32'd0);
    check("rdata0_held", 32'(rr_rdata0), 32'(exp_rd0));
    last_addr = addr;
    last_data = data;
  endtask

  typedef struct {
    logic       port;
    logic       wen;
    logic [3:0] addr;
    logic [7:0] data;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t tbl [9];

  initial begin
    int  seen;
    bit  e_rr0, e_rr1, e_fp0, e_rrd0, e_rrd1;

    tbl[0] = '{1'b0, 1'b1, 4'd3,  8'h5A, 8'h00};
    tbl[1] = '{1'b0, 1'b0, 4'd3,  8'h00, 8'h5A};
    tbl[2] = '{1'b1, 1'b1, 4'd15, 8'hFF, 8'h00};
    tbl[3] = '{1'b0, 1'b0, 4'd15, 8'h00, 8'hFF};
    tbl[4] = '{1'b1, 1'b1, 4'd0,  8'hA5, 8'h00};
    tbl[5] = '{1'b1, 1'b0, 4'd0,  8'h00, 8'hA5};
    tbl[6] = '{1'b0, 1'b1, 4'd2,  8'h33, 8'h00};
    tbl[7] = '{1'b1, 1'b0, 4'd2,  8'hC3, 8'h33};
    tbl[8] = '{1'b0, 1'b0, 4'd3,  8'h00, 8'h5A};

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    check("rst_busy", 32'(rr_busy), 32'd0);
    check("rst_outputs", 32'({rr_gnt0, rr_gnt1, rr_done0, rr_done1, rr_mem_wen}), 32'd0);
    check("rst_mem_addr", 32'(rr_mem_addr), 32'd0);
    check("rst_rdata", 32'({rr_rdata0, rr_rdata1}), 32'd0);
    RST = 1'b0;
    step();

    // Table-driven single-port transactions
    for (int i = 0; i < 9; i++) begin
      do_txn(tbl[i].port, tbl[i].wen, tbl[i].addr, tbl[i].data, tbl[i].exp_rd);
    end

    // Reset during ACCESS of a P0 write to A=2 (A=2 holds 8'h33)
    REQ0 = 1'b1; WEN0 = 1'b1; ADDR0 = 4'd2; DATA0 = 8'h11;
    step();
    check("abort_wen_before", 32'(rr_mem_wen), 32'd1);
    REQ0 = 1'b0;
    #2;
    RST = 1'b1;
    #1;
    check("abort_wen_now", 32'(rr_mem_wen), 32'd0);
    check("abort_busy", 32'(rr_busy), 32'd0);
    check("abort_rdata0", 32'(rr_rdata0), 32'd0);
    #1;
    RST = 1'b0;
    exp_rd0 = '0;
    exp_rd1 = '0;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (rr_done0 || rr_done1 || rr_busy) seen++;
    end
    check("abort_no_done", 32'(seen), 32'd0);
    do_txn(1'b0, 1'b0, 4'd2, 8'h00, 8'h33);

    // REQ1 pulse entirely between edges: must be invisible
    REQ1 = 1'b1; WEN1 = 1'b1; ADDR1 = 4'd9; DATA1 = 8'h77;
    #3;
    REQ1 = 1'b0;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (rr_gnt1 || rr_gnt0 || rr_busy) seen++;
    end
    check("glitch_no_gnt", 32'(seen), 32'd0);
    check("glitch_mem_addr", 32'(rr_mem_addr), 32'(last_addr));
    check("glitch_mem_data", 32'(rr_mem_data), 32'(last_data));
    check("glitch_mem_wen", 32'(rr_mem_wen), 32'd0);

    // Both ports requesting continuously: RR alternates, fixed priority starves P1
    RST = 1'b1;
    #2;
    RST = 1'b0;
    exp_rd0 = '0;
    exp_rd1 = '0;
    REQ0 = 1'b1; WEN0 = 1'b0; ADDR0 = 4'd3;
    REQ1 = 1'b1; WEN1 = 1'b0; ADDR1 = 4'd15;
    for (int k = 1; k <= 12; k++) begin
      step();
      e_rr0  = (k % 3 == 1) && (((k - 1) / 3) % 2 == 0);
      e_rr1  = (k % 3 == 1) && (((k - 1) / 3) % 2 == 1);
      e_fp0  = (k % 3 == 1);
      e_rrd0 = (k % 3 == 0) && (((k / 3) - 1) % 2 == 0);
      e_rrd1 = (k % 3 == 0) && (((k / 3) - 1) % 2 == 1);
      check("rr_gnt0", 32'(rr_gnt0), 32'(e_rr0));
      check("rr_gnt1", 32'(rr_gnt1), 32'(e_rr1));
      check("rr_done0", 32'(rr_done0), 32'(e_rrd0));
      check("rr_done1", 32'(rr_done1), 32'(e_rrd1));
      check("fp_gnt0", 32'(fp_gnt0), 32'(e_fp0));
      check("fp_gnt1", 32'(fp_gnt1), 32'd0);
      check("fp_done1", 32'(fp_done1), 32'd0);
    end
    REQ0 = 1'b0;
    REQ1 = 1'b0;
    check("rr_rdata0_both", 32'(rr_rdata0), 32'h5A);
    check("rr_rdata1_both", 32'(rr_rdata1), 32'hFF);
    check("fp_rdata0_both", 32'(fp_rdata0), 32'h5A);
    repeat (3) step();
    check("final_idle", 32'({rr_busy, fp_busy}), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
